// File: rtl/flex_bus_arbiter_pkg.sv
// Shared types for flex_bus_arbiter: the flex_bus request/response records,
// the data-side and downstream request records, and the arbiter FSM/source enums.
package flex_bus_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } flex_bus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data_1;
        logic [31:0] data_2;
        logic        valid_2;
    } flex_bus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        is_write;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } arb_dreq_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } arb_dresp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        is_write;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        is_instr;
    } arb_oreq_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] ARB_INSTR_SIZE = 2'b10;

    function automatic arb_dresp_t to_dresp(input flex_bus_resp_t r);
        arb_dresp_t d;
        d.addr_ok = r.addr_ok;
        d.data_ok = r.data_ok;
        d.data    = r.data_1;
        return d;
    endfunction

endpackage

// File: rtl/flex_bus_arbiter_pick.sv
// flex_arb_pick: combinational grant policy. Data has priority; with
// FLEX_ARB_STARVE_GUARD_EN a starved instruction request wins once the limit is reached.
module flex_arb_pick
    import flex_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             ivalid_i,
    input  logic             dvalid_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             grant_o,
    output arb_src_t         src_o
);

    logic starved_s;

`ifdef FLEX_ARB_STARVE_GUARD_EN
    assign starved_s = ivalid_i && dvalid_i && (starve_cnt_i == CNT_W'(STARVE_LIMIT));
`else
    logic unused_cnt_s;
    assign unused_cnt_s = ^starve_cnt_i;
    assign starved_s    = 1'b0;
`endif

    // Select the winning requester for the current idle cycle.
    always_comb begin
        grant_o = 1'b0;
        src_o   = SRC_I;
        if (starved_s) begin
            grant_o = 1'b1;
            src_o   = SRC_I;
        end else if (dvalid_i) begin
            grant_o = 1'b1;
            src_o   = SRC_D;
        end else if (ivalid_i) begin
            grant_o = 1'b1;
            src_o   = SRC_I;
        end else begin
            grant_o = 1'b0;
            src_o   = SRC_I;
        end
    end

endmodule

// File: rtl/flex_bus_arbiter.sv
// flex_bus_arbiter: shares one downstream port between instruction fetch and data memory.
// Optional starvation guard enabled by defining FLEX_ARB_STARVE_GUARD_EN.
module flex_bus_arbiter
    import flex_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  flex_bus_req_t  ireq,
    output flex_bus_resp_t iresp,
    input  arb_dreq_t      dreq,
    output arb_dresp_t     dresp,
    output arb_oreq_t      oreq,
    input  flex_bus_resp_t oresp
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q;
    arb_src_t         src_q;
    logic [CNT_W-1:0] starve_cnt_q;
    logic             grant_s;
    arb_src_t         pick_src_s;
    logic             granted_valid_s;

    flex_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .ivalid_i    (ireq.valid),
        .dvalid_i    (dreq.valid),
        .starve_cnt_i(starve_cnt_q),
        .grant_o     (grant_s),
        .src_o       (pick_src_s)
    );

    assign granted_valid_s = (src_q == SRC_I) ? ireq.valid : dreq.valid;

    // Arbitration FSM: grant in idle, present until address accepted, then wait for data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            src_q   <= SRC_I;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_s) begin
                        state_q <= ARB_ISSUE;
                        src_q   <= pick_src_s;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    // A withdrawn request aborts before any downstream handshake.
                    if (!granted_valid_s) begin
                        state_q <= ARB_IDLE;
                    end else if (oresp.addr_ok && oresp.data_ok) begin
                        state_q <= ARB_IDLE;
                    end else if (oresp.addr_ok) begin
                        state_q <= ARB_WAIT;
                    end else begin
                        state_q <= ARB_ISSUE;
                    end
                end
                ARB_WAIT: begin
                    if (oresp.data_ok) begin
                        state_q <= ARB_IDLE;
                    end else begin
                        state_q <= ARB_WAIT;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef FLEX_ARB_STARVE_GUARD_EN
    // Count consecutive data grants taken while an instruction request was waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt_q <= {CNT_W{1'b0}};
        end else if ((state_q == ARB_IDLE) && grant_s) begin
            if ((pick_src_s == SRC_I) || !ireq.valid) begin
                starve_cnt_q <= {CNT_W{1'b0}};
            end else begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
        end else begin
            starve_cnt_q <= starve_cnt_q;
        end
    end
`else
    assign starve_cnt_q = {CNT_W{1'b0}};
`endif

    // Downstream request mirrors the live request of the granted source while issuing.
    always_comb begin
        oreq = '0;
        if (state_q == ARB_ISSUE) begin
            if (src_q == SRC_I) begin
                oreq.valid    = ireq.valid;
                oreq.addr     = ireq.addr;
                oreq.is_write = 1'b0;
                oreq.size     = ARB_INSTR_SIZE;
                oreq.strobe   = 4'b0000;
                oreq.data     = 32'h0000_0000;
                oreq.is_instr = 1'b1;
            end else begin
                oreq.valid    = dreq.valid;
                oreq.addr     = dreq.addr;
                oreq.is_write = dreq.is_write;
                oreq.size     = dreq.size;
                oreq.strobe   = dreq.strobe;
                oreq.data     = dreq.data;
                oreq.is_instr = 1'b0;
            end
        end else begin
            oreq = '0;
        end
    end

    // Route downstream responses only to the owner of the outstanding transaction.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (state_q != ARB_IDLE) begin
            if (src_q == SRC_I) begin
                iresp = oresp;
            end else begin
                dresp = to_dresp(oresp);
            end
        end else begin
            iresp = '0;
            dresp = '0;
        end
    end

endmodule

// File: tb/tb_flex_bus_arbiter.sv
// Randomized self-checking bench for flex_bus_arbiter against a transaction-level model
// (owner of the single outstanding transaction plus an accepted flag).
module tb_flex_bus_arbiter;
    import flex_bus_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic           clk = 1'b0;
    logic           resetn;
    flex_bus_req_t  ireq;
    flex_bus_resp_t iresp;
    arb_dreq_t      dreq;
    arb_dresp_t     dresp;
    arb_oreq_t      oreq;
    flex_bus_resp_t oresp;

    always #5 clk = ~clk;

    flex_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .resetn(resetn),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: owner 0 = nobody, 1 = instruction, 2 = data
    int owner   = 0;
    bit accepted = 1'b0;
    int starve  = 0;
    int grant_k = 0;

    arb_oreq_t      e_oreq;
    flex_bus_resp_t e_iresp;
    arb_dresp_t     e_dresp;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: random traffic, 1: both requesters always valid + instant downstream, 2: reset cycle
    task automatic step(input int mode);
        bit i_acc;
        bit d_acc;
        bit done;
        @(negedge clk);
        resetn = (mode == 2) ? 1'b0 : ((mode == 0 && $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        if (mode == 2) begin
            ireq.valid = 1'b0;
            dreq.valid = 1'b0;
        end else begin
            if (!ireq.valid) begin
                if (mode == 1 || $urandom_range(0, 2) == 0) begin
                    ireq.valid = 1'b1;
                    ireq.addr  = $urandom;
                end
            end else if (mode == 0 && $urandom_range(0, 11) == 0) begin
                ireq.valid = 1'b0;
            end
            if (!dreq.valid) begin
                if (mode == 1 || $urandom_range(0, 2) == 0) begin
                    dreq.valid    = 1'b1;
                    dreq.addr     = $urandom;
                    dreq.is_write = 1'($urandom_range(0, 1));
                    dreq.size     = 2'($urandom_range(0, 2));
                    dreq.strobe   = 4'($urandom_range(0, 15));
                    dreq.data     = $urandom;
                end
            end else if (mode == 0 && $urandom_range(0, 11) == 0) begin
                dreq.valid = 1'b0;
            end
        end

        e_oreq = '0;
        if (owner == 1 && !accepted) begin
            e_oreq.valid    = ireq.valid;
            e_oreq.addr     = ireq.addr;
            e_oreq.size     = 2'b10;
            e_oreq.is_instr = 1'b1;
        end else if (owner == 2 && !accepted) begin
            e_oreq.valid    = dreq.valid;
            e_oreq.addr     = dreq.addr;
            e_oreq.is_write = dreq.is_write;
            e_oreq.size     = dreq.size;
            e_oreq.strobe   = dreq.strobe;
            e_oreq.data     = dreq.data;
        end

        oresp.data_1  = $urandom;
        oresp.data_2  = $urandom;
        oresp.valid_2 = 1'($urandom_range(0, 1));
        oresp.addr_ok = 1'b0;
        oresp.data_ok = 1'b0;
        if (e_oreq.valid) begin
            if (mode == 1 || $urandom_range(0, 1) == 1) begin
                oresp.addr_ok = 1'b1;
                oresp.data_ok = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end else if (owner != 0 && accepted) begin
            oresp.data_ok = (mode == 1) || ($urandom_range(0, 2) == 0);
        end else if (owner == 0 && $urandom_range(0, 5) == 0) begin
            oresp.addr_ok = 1'($urandom_range(0, 1));
            oresp.data_ok = 1'($urandom_range(0, 1));
        end

        e_iresp = '0;
        e_dresp = '0;
        if (owner == 1) begin
            e_iresp = oresp;
        end else if (owner == 2) begin
            e_dresp.addr_ok = oresp.addr_ok;
            e_dresp.data_ok = oresp.data_ok;
            e_dresp.data    = oresp.data_1;
        end

        #1;
        chk_eq("oreq",  128'(oreq),  128'(e_oreq));
        chk_eq("iresp", 128'(iresp), 128'(e_iresp));
        chk_eq("dresp", 128'(dresp), 128'(e_dresp));
        if (mode == 1 && e_oreq.valid) begin
`ifdef FLEX_ARB_STARVE_GUARD_EN
            chk_eq("grant_order", 128'(oreq.is_instr), 128'((grant_k % (LIMIT + 1)) == LIMIT));
`else
            chk_eq("grant_order", 128'(oreq.is_instr), 128'(0));
`endif
            grant_k++;
        end

        i_acc = (owner == 1) && !accepted && ireq.valid && oresp.addr_ok;
        d_acc = (owner == 2) && !accepted && dreq.valid && oresp.addr_ok;

        if (!resetn) begin
            owner = 0; accepted = 1'b0; starve = 0;
        end else if (owner == 0) begin
            if (ireq.valid && dreq.valid && starve == LIMIT
`ifndef FLEX_ARB_STARVE_GUARD_EN
                && 1'b0
`endif
            ) begin
                owner = 1; starve = 0;
            end else if (dreq.valid) begin
                owner = 2; starve = ireq.valid ? starve + 1 : 0;
            end else if (ireq.valid) begin
                owner = 1; starve = 0;
            end
        end else if (!accepted) begin
            done = (owner == 1) ? !ireq.valid : !dreq.valid;
            if (done || (oresp.addr_ok && oresp.data_ok)) owner = 0;
            else if (oresp.addr_ok) accepted = 1'b1;
        end else if (oresp.data_ok) begin
            owner = 0; accepted = 1'b0;
        end

        @(posedge clk);
        #1;
        if (i_acc) ireq.valid = 1'b0;
        if (d_acc) dreq.valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        ireq   = '0;
        dreq   = '0;
        oresp  = '0;
        repeat (2) @(posedge clk);
        step(2);
        repeat (3000) step(0);
        step(2);
        grant_k = 0;
        repeat (40) step(1);
        step(2);
        repeat (200) step(0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
